// File: rtl/flopcmp_pkg.sv
// Shared types, defaults and helpers for the flop compare monitor.
package flopcmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_HALT
  } flopcmp_state_e;

  localparam int unsigned DEF_WARMUP   = 30;
  localparam int unsigned DEF_MAX_FAIL = 16;
  localparam int unsigned DEF_CW       = 32;

  // Widest ok vector the helper accepts; callers pad unused bits with 1s.
  localparam int unsigned OK_W_MAX = 64;

  function automatic logic ok_is_pass(input logic [OK_W_MAX-1:0] vec);
    logic pass;
    pass = 1'b1;
    for (int unsigned i = 0; i < OK_W_MAX; i++) begin
      if (vec[i] !== 1'b1) pass = 1'b0;
    end
    return pass;
  endfunction

endpackage

// File: rtl/flop_compare_monitor_if.sv
// Check-tick input and registered result bundle of the flop compare monitor.
interface flop_compare_monitor_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 32
);
  logic          sample;
  logic [N-1:0]  ok_vec;
  logic          armed;
  logic          fail_sticky;
  logic          halted;
  logic [CW-1:0] check_count;
  logic [CW-1:0] fail_count;
  logic [N-1:0]  first_fail_vec;
  logic [CW-1:0] first_fail_cycle;

  modport master (
    output sample, ok_vec,
    input  armed, fail_sticky, halted, check_count, fail_count,
           first_fail_vec, first_fail_cycle
  );

  modport slave (
    input  sample, ok_vec,
    output armed, fail_sticky, halted, check_count, fail_count,
           first_fail_vec, first_fail_cycle
  );
endinterface

// File: rtl/flopcmp_sat_counter.sv
// Up-counter with enable and async active-high reset; holds at all-ones.
module flopcmp_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/flop_compare_monitor.sv
// Warm-up gated check/failure counter with first-fail capture and halt budget.
// Define FLOPCMP_LOG_EN to print every counted failure in simulation.
module flop_compare_monitor
  import flopcmp_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned WARMUP   = DEF_WARMUP,
  parameter int unsigned MAX_FAIL = DEF_MAX_FAIL,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic                  clk,
  input  logic                  reset,
  flop_compare_monitor_if.slave mon
);

  localparam int unsigned     WW         = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0]   WLOAD      = (WARMUP > 0) ? WW'(WARMUP - 1) : '0;
  localparam logic [CW-1:0]   FAIL_LIMIT = CW'(MAX_FAIL);

  flopcmp_state_e state, state_nxt;
  logic [WW-1:0]  wcnt, wcnt_nxt;

  logic [OK_W_MAX-1:0] ok_pad;
  logic [N-1:0]        ok_known;
  logic                pass;
  logic                check_en;
  logic                fail_en;
  logic                capture_en;
  logic                halt_hit;
  logic [CW-1:0]       cycle_count;

  always_comb begin
    ok_pad        = '1;
    ok_pad[N-1:0] = mon.ok_vec;
    pass          = ok_is_pass(ok_pad);
    ok_known      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ok_known[i] = (mon.ok_vec[i] === 1'b1);
    end
  end

  assign check_en   = (state == ST_CHECK) && mon.sample;
  assign fail_en    = check_en && !pass;
  assign capture_en = fail_en && !mon.fail_sticky;
  // A saturated count wraps to 0 here, which never matches a nonzero limit.
  assign halt_hit   = (MAX_FAIL != 0) && ((mon.fail_count + CW'(1)) == FAIL_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_IDLE: begin
        if (WARMUP == 0) begin
          state_nxt = ST_CHECK;
        end else begin
          state_nxt = ST_WARMUP;
          wcnt_nxt  = WLOAD;
        end
      end
      ST_WARMUP: begin
        if (wcnt == '0) state_nxt = ST_CHECK;
        else            wcnt_nxt  = wcnt - WW'(1);
      end
      ST_CHECK: begin
        if (fail_en && halt_hit) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mon.armed  = (state == ST_CHECK) || (state == ST_HALT);
  assign mon.halted = (state == ST_HALT);

  flopcmp_sat_counter #(.W(CW)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (cycle_count)
  );

  flopcmp_sat_counter #(.W(CW)) u_check_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (check_en),
    .count (mon.check_count)
  );

  flopcmp_sat_counter #(.W(CW)) u_fail_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fail_en),
    .count (mon.fail_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon.fail_sticky      <= 1'b0;
      mon.first_fail_vec   <= '1;
      mon.first_fail_cycle <= '0;
    end else begin
      if (capture_en) begin
        mon.fail_sticky      <= 1'b1;
        mon.first_fail_vec   <= ok_known;
        mon.first_fail_cycle <= cycle_count;
      end
`ifdef FLOPCMP_LOG_EN
      if (fail_en) begin
        $display("flopcmp failure cycle=%0d ok_vec=%b", cycle_count, mon.ok_vec);
      end
`else
`endif
    end
  end

endmodule
